sqrt_cordic_seq: RTL

- Iterative hyperbolic CORDIC square-root core (vectoring mode) for the floating-point sqrt datapath.
- One shared micro-rotation datapath is reused for ITER shift indices, under FSM control.
- Hyperbolic convergence repeats are inserted at indices 4 and 13.
- Exponent travels alongside the mantissa. Valid/ready handshakes on input and output.

---
 rtl/sqrt_cordic_seq_pkg.sv | 30 +++
 rtl/sqrt_microrot.sv | 29 ++
 rtl/sqrt_cordic_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/sqrt_cordic_seq_pkg.sv
// Shared types and constants for the iterative hyperbolic CORDIC square-root core.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift indices that must be executed twice for hyperbolic convergence
    localparam int unsigned REP0 = 4;
    localparam int unsigned REP1 = 13;

    // Hyperbolic CORDIC gain for the repeated sequence, Q3.24 (1.0 = 2^24)
    localparam int unsigned K_H = 32'd13894208;

    function automatic logic is_repeat(input int unsigned i);
        return (i == REP0) || (i == REP1);
    endfunction

    // Number of micro-rotations for shift indices 1..iter including repeats
    function automatic int unsigned num_iter(input int unsigned iter);
        int unsigned n;
        n = iter;
        if (iter >= REP0) n = n + 1;
        if (iter >= REP1) n = n + 1;
        return n;
    endfunction

endpackage

// File: rtl/sqrt_microrot.sv
// One hyperbolic vectoring micro-rotation: drives y toward zero by 2^-i steps.
module sqrt_microrot #(
    parameter int DW = 27,
    parameter int IW = 6
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    input  logic        [IW-1:0] i,
    output logic signed [DW-1:0] x_n,
    output logic signed [DW-1:0] y_n
);

    logic signed [DW-1:0] xs;
    logic signed [DW-1:0] ys;

    // Arithmetic shifts, then add/sub chosen by the sign of y (y == 0 counts as non-negative)
    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        if (!y[DW-1]) begin
            x_n = x - ys;
            y_n = y - xs;
        end else begin
            x_n = x + ys;
            y_n = y + xs;
        end
    end

endmodule

// File: rtl/sqrt_cordic_seq.sv
// Sequential hyperbolic CORDIC square root: one shared micro-rotation reused
// for shift indices 1..ITER with repeats at 4 and 13; exponent passes through.
module sqrt_cordic_seq
    import sqrt_pkg::*;
#(
    parameter int DW   = 27,
    parameter int EW   = 9,
    parameter int ITER = 16,
    parameter int IW   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic        [EW-1:0] exp_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic        [EW-1:0] exp_o,
    output logic                 busy
);

    state_t               state;
    logic signed [DW-1:0] xw;
    logic signed [DW-1:0] yw;
    logic        [EW-1:0] ew;
    logic        [IW-1:0] idx;
    logic                 rep;
    logic signed [DW-1:0] x_n;
    logic signed [DW-1:0] y_n;
    logic                 rep_now;
    logic                 last_iter;

    sqrt_microrot #(
        .DW (DW),
        .IW (IW)
    ) u_rot (
        .x   (xw),
        .y   (yw),
        .i   (idx),
        .x_n (x_n),
        .y_n (y_n)
    );

    // Handshake/status flags and index decode from the current state
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        busy      = (state != IDLE);
        rep_now   = is_repeat(32'(idx)) && !rep;
        last_iter = (idx == IW'(ITER)) && !rep_now;
    end

    // FSM: accept operand, iterate the shared rotation, hold the result until taken.
    // The final rotation's outputs are registered straight into x_o/y_o so the
    // result is visible in the cycle after the last iteration edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            xw        <= '0;
            yw        <= '0;
            ew        <= '0;
            idx       <= '0;
            rep       <= 1'b0;
            x_o       <= '0;
            y_o       <= '0;
            exp_o     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        xw    <= x_i;
                        yw    <= y_i;
                        ew    <= exp_i;
                        idx   <= IW'(1);
                        rep   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    xw <= x_n;
                    yw <= y_n;
                    if (rep_now) begin
                        rep <= 1'b1;
                    end else begin
                        rep <= 1'b0;
                        idx <= idx + 1'b1;
                    end
                    if (last_iter) begin
                        x_o       <= x_n;
                        y_o       <= y_n;
                        exp_o     <= ew;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
